// File: rtl/btn_count_ctrl.sv
// btn_count_ctrl
// Push-button sequencer for the board's up-counter. Three raw buttons are
// synchronized and debounced on the system clock; accepted presses drive
// one-cycle increment / clear strobes toward an external counter whose value
// is fed back on Count so wrap-around can be decided here.
//
// Ports
//    Clk       system clock
//    Reset     synchronous, active-high
//    Btn_Step  raw button: one step per press (ignored while running)
//    Btn_Run   raw button: each press toggles run/stop
//    Btn_Clr   raw button: clears the counter (and stops a run)
//    Count     current counter value, fed back
//    Cnt_En    one-cycle increment strobe
//    Cnt_Clr   one-cycle clear strobe
//    Running   high while in RUN
//    Wrap      one-cycle pulse when a step wraps the counter to 0
//
// Build option: define AUTO_STOP_EN to end a run on its first wrap (a single
// 0..MOD_N-1 sweep). Without it a run free-runs until a Run or Clr press.
//
// state | meaning
// IDLE  | waiting for presses; Step advances by one
// RUN   | prescaler issues a step every TICK_DIV cycles
module btn_count_ctrl #(
   parameter int CNT_W      = 4,
   parameter int MOD_N      = 10,
   parameter int DEB_CYCLES = 4,
   parameter int TICK_DIV   = 4
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             Btn_Step,
   input  logic             Btn_Run,
   input  logic             Btn_Clr,
   input  logic [CNT_W-1:0] Count,
   output logic             Cnt_En,
   output logic             Cnt_Clr,
   output logic             Running,
   output logic             Wrap
);

   localparam int DEB_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
   localparam int PRE_W = $clog2(TICK_DIV);
   localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);
   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MOD_N - 1);

   typedef enum logic {IDLE, RUN} state_t;

   // bit 0 = step, bit 1 = run, bit 2 = clear
   logic [2:0]       raw;
   logic [2:0]       sync1;
   logic [2:0]       sync2;
   logic [1:0]       settle;
   logic [2:0]       deb_lvl;
   logic [DEB_W-1:0] deb_cnt [3];
   logic [2:0]       press;
   logic [2:0]       armed;

   state_t           state;
   logic [PRE_W-1:0] presc;
   logic             at_last;

   assign raw     = {Btn_Clr, Btn_Run, Btn_Step};
   assign at_last = (Count >= CNT_LAST);

   // settle[1] marks the point where the synchronizer again carries real
   // button samples instead of its cleared reset contents.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         sync1  <= '0;
         sync2  <= '0;
         settle <= '0;
      end else begin
         sync1  <= raw;
         sync2  <= sync1;
         settle <= {settle[0], 1'b1};
      end
   end

   // A button only produces presses once it has been seen released after
   // reset, so a button held through reset needs a fresh press.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         deb_lvl <= '0;
         press   <= '0;
         armed   <= '0;
         for (int i = 0; i < 3; i++) deb_cnt[i] <= '0;
      end else begin
         press <= '0;
         for (int i = 0; i < 3; i++) begin
            if (sync2[i] == deb_lvl[i]) begin
               deb_cnt[i] <= '0;
            end else if (deb_cnt[i] != DEB_LAST) begin
               deb_cnt[i] <= deb_cnt[i] + DEB_W'(1);
            end else begin
               deb_lvl[i] <= sync2[i];
               deb_cnt[i] <= '0;
               press[i]   <= sync2[i] & armed[i];
            end
            if (settle[1] && !sync2[i] && !deb_lvl[i]) armed[i] <= 1'b1;
         end
      end
   end

   // Press priority is Clr > Run > Step; a press in RUN also swallows the
   // prescaler tick of that cycle.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state   <= IDLE;
         presc   <= '0;
         Cnt_En  <= 1'b0;
         Cnt_Clr <= 1'b0;
         Wrap    <= 1'b0;
         Running <= 1'b0;
      end else begin
         Cnt_En  <= 1'b0;
         Cnt_Clr <= 1'b0;
         Wrap    <= 1'b0;
         case (state)
            IDLE: begin
               if (press[2]) begin
                  Cnt_Clr <= 1'b1;
               end else if (press[1]) begin
                  state   <= RUN;
                  Running <= 1'b1;
                  presc   <= '0;
               end else if (press[0]) begin
                  if (at_last) begin
                     Cnt_Clr <= 1'b1;
                     Wrap    <= 1'b1;
                  end else begin
                     Cnt_En  <= 1'b1;
                  end
               end
            end
            RUN: begin
               if (press[2]) begin
                  Cnt_Clr <= 1'b1;
                  state   <= IDLE;
                  Running <= 1'b0;
               end else if (press[1]) begin
                  state   <= IDLE;
                  Running <= 1'b0;
               end else if (presc == PRE_LAST) begin
                  presc <= '0;
                  if (at_last) begin
                     Cnt_Clr <= 1'b1;
                     Wrap    <= 1'b1;
`ifdef AUTO_STOP_EN
                     state   <= IDLE;
                     Running <= 1'b0;
`endif
                  end else begin
                     Cnt_En  <= 1'b1;
                  end
               end else begin
                  presc <= presc + PRE_W'(1);
               end
            end
            default: begin
               state   <= IDLE;
               Running <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/btn_count_ctrl.md
# btn_count_ctrl

Push-button sequencer for the board's 4-bit up-counter.
- Takes three raw push buttons (step, run/stop, clear), synchronizes and debounces them, and drives the counter's enable and clear controls.
- Step mode advances by one per press; run mode advances at a prescaled rate. Both wrap modulo MOD_N.
- Sits between the board buttons and the counter datapath, replacing direct button-as-clock drive so the whole design runs on the 100 MHz system clock.

## Interface
Parameters:
- CNT_W, 4, counter width.
- MOD_N, 10, count modulus (2..2^CNT_W).
- DEB_CYCLES, 4, consecutive stable cycles needed to accept a button level (board build: 100000).
- TICK_DIV, 4, cycles between run-mode steps (≥2; board build: 25000000).

Ports (one clock; reset is synchronous and active-high):
- Clk  in  1  system clock.
- Reset  in  1  synchronous, active-high.
- Btn_Step  in  1  raw button, asynchronous, bouncing.
- Btn_Run  in  1  raw button; each press toggles run/stop.
- Btn_Clr  in  1  raw button; clears the counter.
- Count  in  CNT_W  current counter value, fed back.
- Cnt_En  out  1  one-cycle increment strobe.
- Cnt_Clr  out  1  one-cycle clear strobe.
- Running  out  1  high while in RUN.
- Wrap  out  1  one-cycle pulse when a step wraps to 0.

## Operation
- **Reset:** all outputs 0, FSM = IDLE, debounced levels 0, debounce and prescale counters 0.
- **Synchronizer:** each button passes a 2-flop synchronizer, giving sync value s.
- **Debouncer** (per button), holds debounced level d and counter c:
  - s == d → c ← 0.
  - s != d and c < DEB_CYCLES-1 → c ← c+1.
  - s != d and c == DEB_CYCLES-1 → d ← s, c ← 0. If s = 1, emit press pulse p that cycle.
  - Releases emit nothing.
- **Press priority in one cycle:** Clr > Run > Step. Lower-priority presses that cycle are dropped.
- **FSM states:**
  - IDLE:
    - p_clr → issue clear.
    - p_run → RUN, prescaler ← 0.
    - p_step → issue step.
  - RUN:
    - p_clr → issue clear, go to IDLE.
    - p_run → IDLE.
    - p_step ignored.
    - Prescaler counts 0..TICK_DIV-1. On reaching TICK_DIV-1 → issue step, prescaler ← 0.
- **Issue step:** Count is sampled the cycle the step is decided.
  - Count ≥ MOD_N-1 → next cycle Cnt_Clr=1 and Wrap=1, Cnt_En=0.
  - Otherwise → next cycle Cnt_En=1.
  - Out-of-range Count (≥ MOD_N) therefore self-corrects to 0.
- **Issue clear:** next cycle Cnt_Clr=1, Wrap=0, Cnt_En=0.
- **Strobe rules:** Cnt_En and Cnt_Clr are never high together. Each is exactly one cycle wide.
- **Running:** registered; equals (state == RUN).
- **Counter contract:** the counter updates the cycle after the strobe (Cnt_Clr → 0, Cnt_En → +1). TICK_DIV ≥ 2 guarantees the fed-back Count is current at the next decision.

## Timing
- Raw press held stable → press pulse p: 2 + DEB_CYCLES cycles.
- Press pulse → strobe: 1 cycle (registered). Total button edge → Cnt_En/Cnt_Clr: DEB_CYCLES + 3 cycles.
- Bounce shorter than DEB_CYCLES cycles restarts the debounce count; no pulse is produced.
- RUN: first step decided TICK_DIV cycles after entering RUN, then every TICK_DIV cycles. Strobe follows each decision by 1 cycle.
- Reset asserted mid-operation: next edge forces reset values. Any strobe already registered is dropped. A button held through reset must be released and pressed again to register.

## Configuration
- AUTO_STOP_EN defined: in RUN, a wrap step also returns the FSM to IDLE in the same cycle that Cnt_Clr/Wrap assert. Running falls in that cycle, giving a single 0..MOD_N-1 sweep.
- AUTO_STOP_EN undefined: RUN free-runs through wraps until a Run or Clr press.

## Test plan
Bench settings: DEB_CYCLES=4, TICK_DIV=4, MOD_N=10, counter model attached.
- **Reset:** Reset=1 for 2 cycles with buttons low → Cnt_En, Cnt_Clr, Running, Wrap all 0; FSM IDLE.
- **Bounce:** Btn_Step toggles every 2 cycles for 20 cycles, then held high 12 cycles → exactly one Cnt_En pulse, 7 cycles after the final rising edge; Count 0→1.
- **Run and wrap:** press Btn_Run from Count=0 → Running=1; Cnt_En every 4 cycles, Count 1..9. Next step gives Cnt_Clr=1 and Wrap=1, Count=0, Cnt_En=0 that cycle.
- **Priority:** Btn_Clr and Btn_Run rise in the same cycle while in RUN at Count=5 → single Cnt_Clr, Running=0, Count=0, no Wrap.
- **Reset mid-run:** Reset pulsed at Count=3 in RUN → outputs 0 next cycle, Running=0; no further strobes until a new press.
- **Auto-stop:** with AUTO_STOP_EN, run from Count=7 → Cnt_En at 7→8 and 8→9, then Cnt_Clr+Wrap with Running falling in that same cycle; no Cnt_En over the next 20 cycles.
